// File: rtl/parking_pkg.sv
// Constants and small helpers shared by the parking-system blocks.
// Counter sub-modules and tops import this instead of repeating literals.
package parking_pkg;

  localparam int PARK_MAX_ZONES     = 16;
  localparam int PARK_ZONE_IDX_W    = 4;
  localparam int PARK_DEFAULT_CAP   = 15;
  localparam int PARK_ALMOST_MARGIN = 2;

  // What happened in one zone during one clock, after edge detection.
  typedef enum logic [1:0] {
    EV_NONE  = 2'b00,
    EV_ENTRY = 2'b01,
    EV_EXIT  = 2'b10,
    EV_BOTH  = 2'b11
  } zone_event_e;

  function automatic zone_event_e classify_event(input logic entry_ev,
                                                 input logic exit_ev);
    zone_event_e ev;
    ev = EV_NONE;
    if (entry_ev && exit_ev) begin
      ev = EV_BOTH;
    end else if (entry_ev) begin
      ev = EV_ENTRY;
    end else if (exit_ev) begin
      ev = EV_EXIT;
    end
    return ev;
  endfunction

endpackage

// File: rtl/zone_counter.sv
// One parking zone: sensor edge detection, occupancy count, capacity register
// and the derived availability / full flags.
module zone_counter
  import parking_pkg::*;
#(
  parameter int CNT_W         = 6,
  parameter int DEFAULT_CAP   = PARK_DEFAULT_CAP,
  parameter int ALMOST_MARGIN = PARK_ALMOST_MARGIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_passed,
  input  logic             exit_passed,
  input  logic             cap_wr_en,
  input  logic [CNT_W-1:0] cap_wr_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] available,
  output logic             full,
  output logic             almost_full,
  output logic             entry_reject,
  output logic             exit_reject
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             entry_prev_q, entry_prev_d;
  logic             exit_prev_q, exit_prev_d;
  logic             armed_q, armed_d;
  logic             entry_rej_q, entry_rej_d;
  logic             exit_rej_q, exit_rej_d;

  logic             entry_ev;
  logic             exit_ev;
  logic             full_now;
  zone_event_e      zone_ev;

  // armed_q stays low for the first edge after reset so a sensor that is
  // already high only gets its level recorded, never counted.
  always_comb begin
    entry_ev = armed_q & entry_passed & ~entry_prev_q;
    exit_ev  = armed_q & exit_passed  & ~exit_prev_q;
    zone_ev  = classify_event(entry_ev, exit_ev);
    full_now = (count_q >= cap_q);

    count_d      = count_q;
    entry_rej_d  = 1'b0;
    exit_rej_d   = 1'b0;
    entry_prev_d = entry_passed;
    exit_prev_d  = exit_passed;
    armed_d      = 1'b1;
    cap_d        = cap_wr_en ? cap_wr_data : cap_q;

    // Events are judged against cap_q, i.e. the capacity before any write
    // landing on this same edge.
    unique case (zone_ev)
      EV_ENTRY: begin
        if (!full_now) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          entry_rej_d = 1'b1;
        end
      end
      EV_EXIT: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          exit_rej_d = 1'b1;
        end
      end
      EV_BOTH: count_d = count_q;
      EV_NONE: count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q      <= '0;
      cap_q        <= CNT_W'(DEFAULT_CAP);
      entry_prev_q <= 1'b0;
      exit_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      entry_rej_q  <= 1'b0;
      exit_rej_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      cap_q        <= cap_d;
      entry_prev_q <= entry_prev_d;
      exit_prev_q  <= exit_prev_d;
      armed_q      <= armed_d;
      entry_rej_q  <= entry_rej_d;
      exit_rej_q   <= exit_rej_d;
    end
  end

  // A capacity lowered below the current count clamps availability at 0.
  always_comb begin
    count        = count_q;
    full         = (count_q >= cap_q);
    available    = full ? '0 : (cap_q - count_q);
    almost_full  = (32'(available) <= ALMOST_MARGIN);
    entry_reject = entry_rej_q;
    exit_reject  = exit_rej_q;
  end

endmodule

// File: rtl/multi_zone_counter.sv
// Occupancy counter for NUM_ZONES independent parking zones, with the
// lot-wide total and a "first zone with space" hint for guidance signs.
module multi_zone_counter
  import parking_pkg::*;
#(
  parameter int NUM_ZONES     = 4,
  parameter int CNT_W         = 6,
  parameter int DEFAULT_CAP   = PARK_DEFAULT_CAP,
  parameter int ALMOST_MARGIN = PARK_ALMOST_MARGIN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_ZONES-1:0]         entry_passed,
  input  logic [NUM_ZONES-1:0]         exit_passed,
  input  logic                         cap_wr_en,
  input  logic [PARK_ZONE_IDX_W-1:0]   cap_wr_zone,
  input  logic [CNT_W-1:0]             cap_wr_data,
  output logic [NUM_ZONES*CNT_W-1:0]   zone_count,
  output logic [NUM_ZONES*CNT_W-1:0]   zone_available,
  output logic [NUM_ZONES-1:0]         zone_full,
  output logic [NUM_ZONES-1:0]         zone_almost_full,
  output logic [NUM_ZONES-1:0]         entry_reject,
  output logic [NUM_ZONES-1:0]         exit_reject,
  output logic [CNT_W+3:0]             total_count,
  output logic [PARK_ZONE_IDX_W-1:0]   hint_zone,
  output logic                         hint_valid
);

  // Zone indices at or above NUM_ZONES never match a generated zone, so
  // such writes fall on the floor.
  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    logic wr_hit;
    assign wr_hit = cap_wr_en && (cap_wr_zone == PARK_ZONE_IDX_W'(z));

    zone_counter #(
      .CNT_W        (CNT_W),
      .DEFAULT_CAP  (DEFAULT_CAP),
      .ALMOST_MARGIN(ALMOST_MARGIN)
    ) u_zone (
      .clk         (clk),
      .reset       (reset),
      .entry_passed(entry_passed[z]),
      .exit_passed (exit_passed[z]),
      .cap_wr_en   (wr_hit),
      .cap_wr_data (cap_wr_data),
      .count       (zone_count[z*CNT_W +: CNT_W]),
      .available   (zone_available[z*CNT_W +: CNT_W]),
      .full        (zone_full[z]),
      .almost_full (zone_almost_full[z]),
      .entry_reject(entry_reject[z]),
      .exit_reject (exit_reject[z])
    );
  end

  always_comb begin
    total_count = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      total_count = total_count + (CNT_W+4)'(zone_count[z*CNT_W +: CNT_W]);
    end
  end

  // Scan from the top down so the lowest-index non-full zone wins.
  always_comb begin
    hint_zone  = '0;
    hint_valid = 1'b0;
    for (int z = NUM_ZONES - 1; z >= 0; z--) begin
      if (!zone_full[z]) begin
        hint_zone  = PARK_ZONE_IDX_W'(z);
        hint_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_zone_counter.sv
// Bench for multi_zone_counter: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic scored against a zone model.
module tb_multi_zone_counter;

  localparam int N   = 4;
  localparam int W   = 6;
  localparam int TW  = W + 4;
  localparam int CAP = 15;
  localparam int MRG = 2;

  typedef struct packed {
    logic [N*W-1:0] zc;
    logic [N*W-1:0] za;
    logic [N-1:0]   zf;
    logic [N-1:0]   zaf;
    logic [N-1:0]   er;
    logic [N-1:0]   xr;
    logic [TW-1:0]  tot;
    logic [3:0]     hz;
    logic           hv;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct {
    logic [N-1:0] ent;
    logic [N-1:0] ex;
    logic         wr;
    logic [3:0]   wz;
    logic [W-1:0] wd;
    int           cz;
    int           cnt;
    int           av;
    bit           full;
    bit           er;
    bit           xr;
  } vec_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   entry_passed;
  logic [N-1:0]   exit_passed;
  logic           cap_wr_en;
  logic [3:0]     cap_wr_zone;
  logic [W-1:0]   cap_wr_data;
  logic [N*W-1:0] zone_count;
  logic [N*W-1:0] zone_available;
  logic [N-1:0]   zone_full;
  logic [N-1:0]   zone_almost_full;
  logic [N-1:0]   entry_reject;
  logic [N-1:0]   exit_reject;
  logic [TW-1:0]  total_count;
  logic [3:0]     hint_zone;
  logic           hint_valid;

  multi_zone_counter #(
    .NUM_ZONES    (N),
    .CNT_W        (W),
    .DEFAULT_CAP  (CAP),
    .ALMOST_MARGIN(MRG)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .entry_passed    (entry_passed),
    .exit_passed     (exit_passed),
    .cap_wr_en       (cap_wr_en),
    .cap_wr_zone     (cap_wr_zone),
    .cap_wr_data     (cap_wr_data),
    .zone_count      (zone_count),
    .zone_available  (zone_available),
    .zone_full       (zone_full),
    .zone_almost_full(zone_almost_full),
    .entry_reject    (entry_reject),
    .exit_reject     (exit_reject),
    .total_count     (total_count),
    .hint_zone       (hint_zone),
    .hint_valid      (hint_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Zone occupancy as plain integers; a "fresh" zone set has just left reset
  // and only learns the sensor levels on its first clock.
  int  m_cnt  [N];
  int  m_cap  [N];
  bit  m_lvl_e[N];
  bit  m_lvl_x[N];
  bit  m_erej [N];
  bit  m_xrej [N];
  bit  m_fresh;

  logic [OW-1:0] exp_q[$];

  function automatic obs_t model_obs();
    obs_t o;
    int   av;
    o = '0;
    for (int z = 0; z < N; z++) begin
      av = (m_cnt[z] < m_cap[z]) ? (m_cap[z] - m_cnt[z]) : 0;
      o.zc[z*W +: W] = W'(m_cnt[z]);
      o.za[z*W +: W] = W'(av);
      o.zf[z]  = (m_cnt[z] >= m_cap[z]);
      o.zaf[z] = (av <= MRG);
      o.er[z]  = m_erej[z];
      o.xr[z]  = m_xrej[z];
      o.tot    = o.tot + TW'(m_cnt[z]);
    end
    o.hv = 1'b0;
    for (int z = 0; z < N; z++) begin
      if (!o.hv && !o.zf[z]) begin
        o.hv = 1'b1;
        o.hz = 4'(z);
      end
    end
    return o;
  endfunction

  task automatic model_step();
    bit new_e, new_x;
    for (int z = 0; z < N; z++) begin
      if (!reset) begin
        m_cnt[z] = 0; m_cap[z] = CAP; m_lvl_e[z] = 0; m_lvl_x[z] = 0;
        m_erej[z] = 0; m_xrej[z] = 0;
      end else begin
        new_e = !m_fresh && entry_passed[z] && !m_lvl_e[z];
        new_x = !m_fresh && exit_passed[z]  && !m_lvl_x[z];
        m_erej[z] = 0;
        m_xrej[z] = 0;
        if (new_e && !new_x) begin
          if (m_cnt[z] < m_cap[z]) m_cnt[z]++;
          else m_erej[z] = 1;
        end else if (new_x && !new_e) begin
          if (m_cnt[z] > 0) m_cnt[z]--;
          else m_xrej[z] = 1;
        end
        m_lvl_e[z] = entry_passed[z];
        m_lvl_x[z] = exit_passed[z];
        if (cap_wr_en && int'(cap_wr_zone) == z) m_cap[z] = int'(cap_wr_data);
      end
    end
    m_fresh = !reset;
    exp_q.push_back(model_obs());
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score();
    obs_t e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    e = obs_t'(exp_q.pop_front());
    chk("m_zone_count",     64'(zone_count),       64'(e.zc));
    chk("m_zone_available", 64'(zone_available),   64'(e.za));
    chk("m_zone_full",      64'(zone_full),        64'(e.zf));
    chk("m_almost_full",    64'(zone_almost_full), 64'(e.zaf));
    chk("m_entry_reject",   64'(entry_reject),     64'(e.er));
    chk("m_exit_reject",    64'(exit_reject),      64'(e.xr));
    chk("m_total_count",    64'(total_count),      64'(e.tot));
    chk("m_hint_valid",     64'(hint_valid),       64'(e.hv));
    if (e.hv) chk("m_hint_zone", 64'(hint_zone), 64'(e.hz));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    score();
  endtask

  task automatic drive(input logic [N-1:0] ent, input logic [N-1:0] ex);
    entry_passed = ent;
    exit_passed  = ex;
    cap_wr_en    = 1'b0;
    step();
  endtask

  task automatic write_cap(input int z, input int val);
    cap_wr_en   = 1'b1;
    cap_wr_zone = 4'(z);
    cap_wr_data = W'(val);
    step();
    cap_wr_en   = 1'b0;
  endtask

  task automatic expect_zone(input string tag, input int z, input int cnt, input int av,
                             input bit full, input bit er, input bit xr);
    chk({tag, "_count"}, 64'(zone_count[z*W +: W]),     64'(cnt));
    chk({tag, "_avail"}, 64'(zone_available[z*W +: W]), 64'(av));
    chk({tag, "_full"},  64'(zone_full[z]),             64'(full));
    chk({tag, "_erej"},  64'(entry_reject[z]),          64'(er));
    chk({tag, "_xrej"},  64'(exit_reject[z]),           64'(xr));
  endtask

  // ---------------- test ----------------
  vec_t vt[12];

  initial begin
    reset        = 1'b0;
    entry_passed = '0;
    exit_passed  = '0;
    cap_wr_en    = 1'b0;
    cap_wr_zone  = '0;
    cap_wr_data  = '0;
    m_fresh      = 1'b1;

    vt[0]  = '{ent:4'b0001, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[1]  = '{ent:4'b0001, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[2]  = '{ent:4'b0001, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[3]  = '{ent:4'b0001, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[4]  = '{ent:4'b0001, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[5]  = '{ent:4'b0000, ex:4'b0000, wr:0, wz:0, wd:0, cz:0, cnt:1, av:14, full:0, er:0, xr:0};
    vt[6]  = '{ent:4'b0000, ex:4'b0010, wr:0, wz:0, wd:0, cz:1, cnt:0, av:15, full:0, er:0, xr:1};
    vt[7]  = '{ent:4'b0000, ex:4'b0000, wr:0, wz:0, wd:0, cz:1, cnt:0, av:15, full:0, er:0, xr:0};
    vt[8]  = '{ent:4'b0000, ex:4'b0000, wr:1, wz:1, wd:0, cz:1, cnt:0, av:0,  full:1, er:0, xr:0};
    vt[9]  = '{ent:4'b0010, ex:4'b0000, wr:0, wz:0, wd:0, cz:1, cnt:0, av:0,  full:1, er:1, xr:0};
    vt[10] = '{ent:4'b0000, ex:4'b0000, wr:0, wz:0, wd:0, cz:1, cnt:0, av:0,  full:1, er:0, xr:0};
    vt[11] = '{ent:4'b0000, ex:4'b0000, wr:1, wz:9, wd:3, cz:0, cnt:1, av:14, full:0, er:0, xr:0};

    // Reset state
    step();
    step();
    chk("rst_total", 64'(total_count), 64'd0);
    chk("rst_hint_valid", 64'(hint_valid), 64'd1);
    chk("rst_hint_zone", 64'(hint_zone), 64'd0);
    chk("rst_avail", 64'(zone_available), 64'({N{W'(CAP)}}));
    chk("rst_full", 64'(zone_full), 64'd0);
    reset = 1'b1;
    step();

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      entry_passed = vt[i].ent;
      exit_passed  = vt[i].ex;
      cap_wr_en    = vt[i].wr;
      cap_wr_zone  = vt[i].wz;
      cap_wr_data  = vt[i].wd;
      step();
      expect_zone($sformatf("vec%0d", i), vt[i].cz, vt[i].cnt, vt[i].av,
                  vt[i].full, vt[i].er, vt[i].xr);
    end
    cap_wr_en = 1'b0;

    // Zone 0 filled by a smaller cap so the hint has to skip zones 0..2.
    write_cap(0, 1);
    expect_zone("z0_cap1", 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(4'b0100, 4'b0000);
      if (i == 14) begin
        expect_zone("z2_fill", 2, 15, 0, 1, 0, 0);
        chk("z2_almost", 64'(zone_almost_full[2]), 64'd1);
      end
      if (i == 15) expect_zone("z2_over", 2, 15, 0, 1, 1, 0);
      drive(4'b0000, 4'b0000);
      if (i == 15) expect_zone("z2_over_end", 2, 15, 0, 1, 0, 0);
    end
    chk("hint_skip", 64'(hint_zone), 64'd3);
    chk("hint_skip_valid", 64'(hint_valid), 64'd1);

    // Simultaneous entry and exit at full: no change, no reject.
    drive(4'b0100, 4'b0100);
    expect_zone("z2_both", 2, 15, 0, 1, 0, 0);
    drive(4'b0000, 4'b0000);

    // Capacity cut below the count.
    for (int i = 0; i < 8; i++) begin
      drive(4'b1000, 4'b0000);
      drive(4'b0000, 4'b0000);
    end
    expect_zone("z3_eight", 3, 8, 7, 0, 0, 0);
    write_cap(3, 5);
    expect_zone("z3_cap5", 3, 8, 0, 1, 0, 0);
    chk("all_full_hint", 64'(hint_valid), 64'd0);
    drive(4'b1000, 4'b0000);
    expect_zone("z3_rej", 3, 8, 0, 1, 1, 0);
    drive(4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b1000);
      drive(4'b0000, 4'b0000);
    end
    expect_zone("z3_five", 3, 5, 0, 1, 0, 0);
    drive(4'b0000, 4'b1000);
    expect_zone("z3_four", 3, 4, 1, 0, 0, 0);
    chk("z3_almost", 64'(zone_almost_full[3]), 64'd1);
    chk("hint_back", 64'(hint_zone), 64'd3);
    drive(4'b0000, 4'b0000);

    // Fresh reset, then all zones at once and reset in the middle of traffic.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    drive(4'b1111, 4'b0000);
    chk("all4_total", 64'(total_count), 64'd4);
    drive(4'b0000, 4'b0000);
    drive(4'b1111, 4'b0000);
    chk("all8_total", 64'(total_count), 64'd8);
    drive(4'b0000, 4'b0000);
    reset = 1'b0;
    drive(4'b1111, 4'b1111);
    chk("midrst_total", 64'(total_count), 64'd0);
    chk("midrst_rej", 64'({entry_reject, exit_reject}), 64'd0);
    chk("midrst_avail", 64'(zone_available), 64'({N{W'(CAP)}}));
    chk("midrst_hint_valid", 64'(hint_valid), 64'd1);
    reset = 1'b1;
    drive(4'b1111, 4'b0000);
    chk("held_after_rst", 64'(total_count), 64'd0);
    drive(4'b1111, 4'b0000);
    chk("held_after_rst2", 64'(total_count), 64'd0);
    drive(4'b0000, 4'b0000);
    drive(4'b0001, 4'b0000);
    chk("new_edge_total", 64'(total_count), 64'd1);
    drive(4'b0000, 4'b0000);

    // Cap write and entry together: entry judged against the old cap.
    entry_passed = 4'b0001;
    write_cap(0, 1);
    expect_zone("wr_and_entry", 0, 2, 0, 1, 0, 0);
    drive(4'b0000, 4'b0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      entry_passed = N'($urandom_range(0, (1 << N) - 1));
      exit_passed  = N'($urandom_range(0, (1 << N) - 1));
      cap_wr_en    = ($urandom_range(0, 7) == 0);
      cap_wr_zone  = 4'($urandom_range(0, 15));
      cap_wr_data  = W'($urandom_range(0, 20));
      reset        = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    drive(4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_zone_counter.md
MULTI_ZONE_COUNTER -- requirements
Module: multi_zone_counter

Interface
REQ-001 Parameter NUM_ZONES, default 4, number of independently counted parking zones (1..16).
REQ-002 Parameter CNT_W, default 6, width of every per-zone count, capacity and availability field.
REQ-003 Parameter DEFAULT_CAP, default 15, per-zone capacity loaded at reset (must be less than 2^CNT_W).
REQ-004 Parameter ALMOST_MARGIN, default 2, availability at or below which almost_full asserts.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-007 entry_passed  input  NUM_ZONES  per-zone entry sensor level, may be held high for many cycles.
REQ-008 exit_passed  input  NUM_ZONES  per-zone exit sensor level, may be held high for many cycles.
REQ-009 cap_wr_en  input  1  single-cycle capacity write strobe.
REQ-010 cap_wr_zone  input  4  target zone index; writes with index >= NUM_ZONES are ignored.
REQ-011 cap_wr_data  input  CNT_W  new capacity value.
REQ-012 zone_count  output  NUM_ZONES*CNT_W  packed per-zone counts, zone 0 in LSBs.
REQ-013 zone_available  output  NUM_ZONES*CNT_W  packed per-zone free spaces.
REQ-014 zone_full / zone_almost_full  output  NUM_ZONES each  per-zone flags.
REQ-015 entry_reject / exit_reject  output  NUM_ZONES each  one-cycle rejection pulses.
REQ-016 total_count  output  CNT_W+4  sum of all zone counts.
REQ-017 hint_zone  output  4  lowest-index non-full zone; hint_valid  output  1  high when any zone is non-full.

Function
REQ-018 Event detection: entry event = rising edge of entry_passed[z] (registered previous sample); a held-high level counts once.
REQ-019 Counts, capacities and reject pulses are registered; available, full, almost_full, total_count and hint are combinational from registered state (1-cycle latency from the sampled rising edge).
REQ-020 Entry only (zone not full): count+1; entry when full: count unchanged, entry_reject[z] pulses for 1 cycle.
REQ-021 Exit only (count > 0): count-1; exit at count 0: count stays 0, exit_reject[z] pulses.
REQ-022 Entry and exit events together in the same zone and cycle: count unchanged, no reject pulse, regardless of full or empty state.
REQ-023 zone_available = cap - count when count < cap, else 0; no wrap-around.
REQ-024 zone_full = (count >= cap); zone_almost_full = (available <= ALMOST_MARGIN).
REQ-025 A capacity write takes effect on the next edge. Count is never modified by a write. If count > new cap: full=1, available=0, entries rejected, exits still decrement.
REQ-026 A capacity write and an event in the same zone and cycle: the event is judged against the old capacity.
REQ-027 Zones are fully independent; events in different zones in the same cycle are all processed.
REQ-028 Capacity 0 is legal: the zone is permanently full.

Reset
REQ-029 While reset==0 at a clock edge, the following take their reset values: all counts=0, capacities=DEFAULT_CAP, edge registers=0, reject pulses=0.
REQ-030 Consequential reset outputs: available=DEFAULT_CAP, full=0 (DEFAULT_CAP>0), total_count=0, hint_zone=0, hint_valid=1.
REQ-031 A sensor already high when reset releases does not produce an event; a new rising edge is required.
REQ-032 Reset mid-operation discards pending events and rejects in that cycle.

Structure
REQ-033 Shared package parking_pkg holds DEFAULT_CAP, ALMOST_MARGIN and zone-index width constants used across the parking system.
REQ-034 Sub-module zone_counter contains one zone's edge detection, count, capacity register and flags; the top instantiates NUM_ZONES copies in a generate loop and adds the total and hint logic.

Verification
REQ-035 Defaults. Hold entry_passed[0] high for 5 cycles -> zone 0 count=1, available=14.
REQ-036 Pulse entry on zone 2 sixteen times -> count=15, full=1, almost_full=1; the 16th pulse produces a 1-cycle entry_reject[2]; hint_zone skips zone 2.
REQ-037 Zone 1 empty, exit pulse -> count=0, exit_reject[1] pulses; then simultaneous entry+exit on zone 2 at full -> count stays 15, no reject.
REQ-038 Zone 3 count=8, write cap=5 -> full=1, available=0, entry rejected; three exits -> count=5, full=1; fourth exit -> count=4, full=0.
REQ-039 Entries on zones 0-3 in the same cycle -> total_count increments by 4 one cycle later; assert reset mid-run -> all counts=0, caps=15, hint_valid=1.
